// File: rtl/axi_intr_ctrl.sv
// AXI4-Lite interrupt controller: per-source polarity and edge/level
// selection, W1C pending bits and one aggregated irq output.
module axi_intr_ctrl #(
  parameter int          C_NUM_INTR         = 1,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter bit          C_IRQ_SENSITIVITY  = 1'b0,
  parameter bit          C_IRQ_ACTIVE_STATE = 1'b1,
  parameter logic [31:0] C_MODE_RESET       = 32'hFFFF_FFFF
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_NUM_INTR-1:0]         intr_in,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic                          irq
);
  localparam int N = C_NUM_INTR;
  localparam int AW = C_S_AXI_ADDR_WIDTH;

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  function automatic logic [N-1:0] merge(input logic [N-1:0] old,
                                         input logic [31:0] data,
                                         input logic [31:0] mask);
    logic [31:0] m;
    m = (32'(old) & ~mask) | (data & mask);
    return m[N-1:0];
  endfunction

  // Offsets 0x20 and above are unmapped.
  function automatic logic in_map(input logic [AW-1:0] a);
    return (a >> 5) == '0;
  endfunction

  logic          gie;
  logic [N-1:0]  ier, mode, polarity, pending;
  logic [N-1:0]  act_p0, act_p1, evt, iar_clr, isr_set, wnb;
  logic          aw_rdy, b_vld, ar_rdy, r_vld;
  logic [1:0]    b_resp, r_resp;
  logic [31:0]   r_data, rmux, wmask;
  logic          wr_en, wr_ok, rd_en, rd_ok;
  logic [2:0]    wr_sel;
  logic          cond, cond_p1, irq_p1;
  logic          unused;

  assign wmask  = lane_mask(S_AXI_WSTRB);
  assign wnb    = S_AXI_WDATA[N-1:0] & wmask[N-1:0];
  assign wr_en  = aw_rdy & S_AXI_AWVALID & S_AXI_WVALID;
  assign wr_ok  = in_map(S_AXI_AWADDR);
  assign wr_sel = S_AXI_AWADDR[4:2];
  assign rd_en  = ar_rdy & S_AXI_ARVALID;
  assign rd_ok  = in_map(S_AXI_ARADDR);

  assign iar_clr = (wr_en && wr_ok && wr_sel == 3'd3) ? wnb : '0;
  assign isr_set = (wr_en && wr_ok && wr_sel == 3'd7) ? wnb : '0;
  assign evt     = act_p0 & (~mode | ~act_p1);
  assign cond    = gie & (|(pending & ier));

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = aw_rdy;
  assign S_AXI_BVALID  = b_vld;
  assign S_AXI_BRESP   = b_resp;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID  = r_vld;
  assign S_AXI_RRESP   = r_resp;
  assign S_AXI_RDATA   = r_data;
  assign irq           = irq_p1;

  assign unused = ^{S_AXI_WDATA, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Write channel: one-cycle ready pulse, response held until accepted.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_rdy <= 1'b0;
      b_vld  <= 1'b0;
      b_resp <= 2'b00;
    end else begin
      aw_rdy <= S_AXI_AWVALID & S_AXI_WVALID & ~b_vld & ~aw_rdy;
      if (wr_en) begin
        b_vld  <= 1'b1;
        b_resp <= wr_ok ? 2'b00 : 2'b10;
      end else if (S_AXI_BREADY) begin
        b_vld <= 1'b0;
      end
    end
  end

  // Software-visible configuration registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      gie      <= 1'b0;
      ier      <= '0;
      mode     <= C_MODE_RESET[N-1:0];
      polarity <= '0;
    end else if (wr_en && wr_ok) begin
      case (wr_sel)
        3'd0:    gie      <= wmask[0] ? S_AXI_WDATA[0] : gie;
        3'd1:    ier      <= merge(ier, S_AXI_WDATA, wmask);
        3'd5:    mode     <= merge(mode, S_AXI_WDATA, wmask);
        3'd6:    polarity <= merge(polarity, S_AXI_WDATA, wmask);
        default: ;
      endcase
    end
  end

  // Stage p0: polarity-corrected source; p1: its one-cycle delay; pending latch.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      act_p0  <= '0;
      act_p1  <= '0;
      pending <= '0;
    end else begin
      act_p0  <= intr_in ^ polarity;
      act_p1  <= act_p0;
      pending <= (pending & ~iar_clr) | (evt & ier) | isr_set;
    end
  end

  // Stage p1: registered irq, either level-following or rising-edge pulse.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cond_p1 <= 1'b0;
      irq_p1  <= ~C_IRQ_ACTIVE_STATE;
    end else begin
      cond_p1 <= cond;
      if (C_IRQ_SENSITIVITY ? (cond & ~cond_p1) : cond)
        irq_p1 <= C_IRQ_ACTIVE_STATE;
      else
        irq_p1 <= ~C_IRQ_ACTIVE_STATE;
    end
  end

  // Read data mux; IAR is write-only and ISR reads back the pending set.
  always_comb begin
    rmux = '0;
    case (S_AXI_ARADDR[4:2])
      3'd0:    rmux = {31'b0, gie};
      3'd1:    rmux = 32'(ier);
      3'd2:    rmux = 32'(act_p0);
      3'd4:    rmux = 32'(pending);
      3'd5:    rmux = 32'(mode);
      3'd6:    rmux = 32'(polarity);
      3'd7:    rmux = 32'(pending);
      default: rmux = '0;
    endcase
  end

  // Read channel: one-cycle ready pulse, data registered and held until accepted.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ar_rdy <= 1'b0;
      r_vld  <= 1'b0;
      r_resp <= 2'b00;
      r_data <= '0;
    end else begin
      ar_rdy <= S_AXI_ARVALID & ~r_vld & ~ar_rdy;
      if (rd_en) begin
        r_vld  <= 1'b1;
        r_resp <= rd_ok ? 2'b00 : 2'b10;
        r_data <= rd_ok ? rmux : 32'h0;
      end else if (S_AXI_RREADY) begin
        r_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_intr_ctrl.sv
// Scoreboard bench for axi_intr_ctrl: a level-style and a pulse-style
// instance share all stimulus; a register-level model predicts responses.
module tb_axi_intr_ctrl;
  localparam int N  = 4;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   intr;
  logic [AW-1:0]  awaddr, araddr;
  logic           awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]    wdata;
  logic [3:0]     wstrb;

  logic           awready_a, wready_a, bvalid_a, arready_a, rvalid_a, irq_a;
  logic [1:0]     bresp_a, rresp_a;
  logic [31:0]    rdata_a;
  logic           irq_b;
  logic           unused_awready_b, unused_wready_b, unused_bvalid_b;
  logic           unused_arready_b, unused_rvalid_b;
  logic [1:0]     unused_bresp_b, unused_rresp_b;
  logic [31:0]    unused_rdata_b;

  axi_intr_ctrl #(.C_NUM_INTR(N), .C_S_AXI_ADDR_WIDTH(AW), .C_IRQ_SENSITIVITY(1'b0),
                  .C_IRQ_ACTIVE_STATE(1'b1), .C_MODE_RESET(32'hFFFF_FFFF)) dut_lvl (
    .ACLK(clk), .ARESET(rst), .intr_in(intr),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_a),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_a),
    .S_AXI_BRESP(bresp_a), .S_AXI_BVALID(bvalid_a), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_a),
    .S_AXI_RDATA(rdata_a), .S_AXI_RRESP(rresp_a), .S_AXI_RVALID(rvalid_a), .S_AXI_RREADY(rready),
    .irq(irq_a));

  axi_intr_ctrl #(.C_NUM_INTR(N), .C_S_AXI_ADDR_WIDTH(AW), .C_IRQ_SENSITIVITY(1'b1),
                  .C_IRQ_ACTIVE_STATE(1'b1), .C_MODE_RESET(32'hFFFF_FFFF)) dut_pls (
    .ACLK(clk), .ARESET(rst), .intr_in(intr),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(unused_awready_b),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(unused_wready_b),
    .S_AXI_BRESP(unused_bresp_b), .S_AXI_BVALID(unused_bvalid_b), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(unused_arready_b),
    .S_AXI_RDATA(unused_rdata_b), .S_AXI_RRESP(unused_rresp_b), .S_AXI_RVALID(unused_rvalid_b),
    .S_AXI_RREADY(rready), .irq(irq_b));

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: no handshake within cycle budget at %0t", nm, $time);
  endtask

  // Reference model of the programmer-visible state.
  logic         m_gie, m_cond_d, e_lvl, e_pls;
  logic [N-1:0] m_ier, m_mode, m_pol, m_pend, m_act, m_actd;
  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  rexp_t      rq[$];
  logic [1:0] bq[$];

  function automatic logic [N-1:0] wbits();
    logic [31:0] m;
    m = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    return wdata[N-1:0] & m[N-1:0];
  endfunction

  function automatic logic [N-1:0] wfield(input logic [N-1:0] old);
    logic [N-1:0] keep;
    logic [31:0] m;
    m = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    keep = old & ~m[N-1:0];
    return keep | wbits();
  endfunction

  function automatic logic wr_hs();
    return awready_a && awvalid && wvalid;
  endfunction

  function automatic logic m_cond();
    return m_gie && ((m_pend & m_ier) != '0);
  endfunction

  function automatic logic [N-1:0] m_next_pend();
    logic [N-1:0] ev, clr, set;
    ev  = m_mode & m_act & ~m_actd | ~m_mode & m_act;
    clr = '0;
    set = '0;
    if (wr_hs() && awaddr == 6'h0C) clr = wbits();
    if (wr_hs() && awaddr == 6'h1C) set = wbits();
    return (m_pend & ~clr) | (ev & m_ier) | set;
  endfunction

  function automatic logic [31:0] m_read(input logic [AW-1:0] a);
    if (a > 6'h1C) return 32'h0;
    case (a[4:2])
      3'd0:    return {31'b0, m_gie};
      3'd1:    return 32'(m_ier);
      3'd2:    return 32'(m_act);
      3'd4:    return 32'(m_pend);
      3'd5:    return 32'(m_mode);
      3'd6:    return 32'(m_pol);
      3'd7:    return 32'(m_pend);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_gie <= 1'b0; m_ier <= '0; m_mode <= '1; m_pol <= '0; m_pend <= '0;
      m_act <= '0; m_actd <= '0; m_cond_d <= 1'b0; e_lvl <= 1'b0; e_pls <= 1'b0;
      rq.delete();
      bq.delete();
    end else begin
      m_act    <= intr ^ m_pol;
      m_actd   <= m_act;
      m_pend   <= m_next_pend();
      m_cond_d <= m_cond();
      e_lvl    <= m_cond();
      e_pls    <= m_cond() & ~m_cond_d;
      if (wr_hs()) begin
        case (awaddr)
          6'h00:   m_gie  <= wstrb[0] ? wdata[0] : m_gie;
          6'h04:   m_ier  <= wfield(m_ier);
          6'h14:   m_mode <= wfield(m_mode);
          6'h18:   m_pol  <= wfield(m_pol);
          default: ;
        endcase
        bq.push_back(awaddr <= 6'h1C ? 2'b00 : 2'b10);
      end
      if (arready_a && arvalid)
        rq.push_back('{m_read(araddr), (araddr <= 6'h1C) ? 2'b00 : 2'b10});
    end
  end

  // Monitor: irq every cycle, responses whenever a channel transfers.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("irq_level", {31'b0, irq_a}, {31'b0, e_lvl});
      check("irq_pulse", {31'b0, irq_b}, {31'b0, e_pls});
      if (bvalid_a && bready) begin
        if (bq.size() == 0) timeout("bresp_unexpected");
        else check("bresp", {30'b0, bresp_a}, {30'b0, bq.pop_front()});
      end
      if (rvalid_a && rready) begin
        if (rq.size() == 0) timeout("rdata_unexpected");
        else begin
          rexp_t e;
          e = rq.pop_front();
          check("rdata", rdata_a, e.data);
          check("rresp", {30'b0, rresp_a}, {30'b0, e.resp});
        end
      end
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready_a && n < 20);
    if (!awready_a) timeout("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid_a && n < 20) begin @(negedge clk); n++; end
    if (!bvalid_a) timeout("bvalid");
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready_a && n < 20);
    if (!arready_a) timeout("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid_a && n < 20) begin @(negedge clk); n++; end
    if (!rvalid_a) timeout("rvalid");
    d = rdata_a; r = rresp_a;
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string nm, input logic [AW-1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0] r;
    rd(a, d, r);
    check(nm, d, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0] r;
    int cnt, n;
    rst = 1'b1; intr = '0; awaddr = '0; araddr = '0; awvalid = 1'b0; wvalid = 1'b0;
    wdata = '0; wstrb = 4'hF; bready = 1'b1; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_irq", {31'b0, irq_a}, 32'h0);
    check("rst_irq_pulse", {31'b0, irq_b}, 32'h0);
    check("rst_ready", {30'b0, awready_a, arready_a}, 32'h0);
    check("rst_valid", {30'b0, bvalid_a, rvalid_a}, 32'h0);
    check("rst_rdata", rdata_a, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; chk_en = 1'b1;

    // Reset values of the register map
    for (int i = 0; i < 8; i++)
      rd_chk("rst_reg", 6'(i * 4), (i == 5) ? 32'hF : 32'h0);

    // Edge-mode pulse on source 2
    wr(6'h00, 32'h1, 4'hF);
    wr(6'h04, 32'hF, 4'hF);
    intr[2] = 1'b1; cycles(1); intr[2] = 1'b0;
    cycles(3);
    rd_chk("edge_pend", 6'h10, 32'h4);
    check("edge_irq", {31'b0, irq_a}, 32'h1);
    wr(6'h0C, 32'h4, 4'hF);
    rd_chk("edge_clear", 6'h10, 32'h0);
    check("edge_irq_clr", {31'b0, irq_a}, 32'h0);

    // Level mode: still-active source re-pends after clear
    wr(6'h14, 32'h0, 4'hF);
    intr[1] = 1'b1; cycles(4);
    wr(6'h0C, 32'h2, 4'hF);
    rd_chk("level_repend", 6'h10, 32'h2);
    intr[1] = 1'b0; cycles(4);
    wr(6'h0C, 32'h2, 4'hF);
    rd_chk("level_clear", 6'h10, 32'h0);
    wr(6'h14, 32'hF, 4'hF);

    // Active-low source 0: falling edge pends, rising does not
    intr[0] = 1'b1; cycles(3);
    wr(6'h18, 32'h1, 4'hF);
    wr(6'h0C, 32'hF, 4'hF);
    rd_chk("pol_base", 6'h10, 32'h0);
    intr[0] = 1'b0; cycles(4);
    rd_chk("pol_fall", 6'h10, 32'h1);
    wr(6'h0C, 32'h1, 4'hF);
    intr[0] = 1'b1; cycles(4);
    rd_chk("pol_rise", 6'h10, 32'h0);
    intr[0] = 1'b0; cycles(3);
    wr(6'h18, 32'h0, 4'hF);
    wr(6'h0C, 32'hF, 4'hF);
    rd_chk("pol_restore", 6'h10, 32'h0);

    // Masking, software set, global enable
    wr(6'h04, 32'h0, 4'hF);
    intr[3] = 1'b1; cycles(1); intr[3] = 1'b0; cycles(4);
    rd_chk("masked_pend", 6'h10, 32'h0);
    wr(6'h00, 32'h0, 4'hF);
    wr(6'h04, 32'h8, 4'hF);
    wr(6'h1C, 32'h8, 4'hF);
    rd_chk("isr_pend", 6'h10, 32'h8);
    check("isr_irq_off", {31'b0, irq_a}, 32'h0);
    wr(6'h00, 32'h1, 4'hF);
    check("gie_irq_on", {31'b0, irq_a}, 32'h1);
    wr(6'h0C, 32'hF, 4'hF);

    // Back-to-back sources produce a single pulse
    wr(6'h04, 32'hF, 4'hF);
    cnt = 0;
    intr[0] = 1'b1; cycles(1);
    intr[0] = 1'b0; intr[1] = 1'b1; cycles(1);
    intr[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); cnt += int'(irq_b); end
    check("single_pulse", 32'(cnt), 32'h1);
    @(posedge clk); #1;
    rd_chk("b2b_pend", 6'h10, 32'h3);
    wr(6'h0C, 32'hF, 4'hF);

    // Unmapped offset
    rd(6'h20, d, r);
    check("slverr_data", d, 32'h0);
    check("slverr_resp", {30'b0, r}, 32'h2);
    wr(6'h24, 32'hFFFF_FFFF, 4'hF);

    // Byte-lane strobe: lane 1 only touches bits 15:8
    wr(6'h04, 32'h0000_0005, 4'h2);
    rd_chk("strobe_ier", 6'h04, 32'hF);

    // BREADY stall holds BVALID and blocks a second write
    bready = 1'b0;
    awaddr = 6'h04; wdata = 32'h5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready_a && n < 20);
    if (!awready_a) timeout("stall_aw1");
    @(posedge clk); #1;
    wdata = 32'hA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_bvalid", {31'b0, bvalid_a}, 32'h1);
      check("stall_awready", {31'b0, awready_a}, 32'h0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready_a && n < 20);
    if (!awready_a) timeout("stall_aw2");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    cycles(3);
    rd_chk("stall_ier", 6'h04, 32'hA);

    // Randomised traffic against the model
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 2))
        0: wr(6'($urandom_range(0, 9) * 4), $urandom, 4'($urandom_range(0, 15)));
        1: rd(6'($urandom_range(0, 9) * 4), d, r);
        default: begin
          intr = N'($urandom);
          cycles($urandom_range(1, 3));
        end
      endcase
    end

    cycles(5);
    check("rq_drained", 32'(rq.size()), 32'h0);
    check("bq_drained", 32'(bq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_intr_ctrl.md
# axi_intr_ctrl

Parametrised AXI4-Lite interrupt controller for the display-pipeline IP cores (VGA buffer, frame DMA, timing generator). It collects up to 32 interrupt sources, supports per-source edge/level and polarity selection, latches enabled events into W1C pending bits, and drives one aggregated `irq` line. Register offsets 0x00/0x04/0x0C/0x10 keep the existing single-source interrupt map, so current drivers and benches run unchanged.

## Interface
- `C_NUM_INTR`, 1: number of interrupt sources (1..32).
- `C_S_AXI_ADDR_WIDTH`, 5: AXI-Lite address width (min 5).
- `C_IRQ_SENSITIVITY`, 0: `irq` output style; 0 = level, 1 = one-cycle pulse.
- `C_IRQ_ACTIVE_STATE`, 1: asserted value of `irq`.
- `C_MODE_RESET`, all ones: reset value of MODE (1 = edge).
- `ACLK  in  1  clock`
- `ARESET  in  1  reset` (one clock; reset is synchronous and active-high)
- `intr_in  in  C_NUM_INTR  interrupt sources`; synchronous to ACLK, no synchroniser.
- `S_AXI_AWADDR/AWVALID/AWREADY`: write address channel, standard AXI4-Lite.
- `S_AXI_WDATA[31:0]/WSTRB[3:0]/WVALID/WREADY`: write data channel.
- `S_AXI_BRESP[1:0]/BVALID/BREADY`: write response channel.
- `S_AXI_ARADDR/ARVALID/ARREADY`: read address channel.
- `S_AXI_RDATA[31:0]/RRESP[1:0]/RVALID/RREADY`: read data channel.
- `irq  out  1  aggregated interrupt`

## Operation
- Register map (word offsets; bits at or above C_NUM_INTR read 0 and ignore writes):
  - 0x00 GIE, bit0 RW.
  - 0x04 IER, RW.
  - 0x08 STATUS, RO. Polarity-corrected live source.
  - 0x0C IAR, WO. Writing 1 clears the matching PENDING bit. Reads return 0.
  - 0x10 PENDING, RO.
  - 0x14 MODE, RW. 1 = edge, 0 = level.
  - 0x18 POLARITY, RW. 1 = active-low.
  - 0x1C ISR, RW1S. Software sets PENDING bits, for test.
- Offsets above 0x1C: write ignored, read data 0, response SLVERR (2'b10). Mapped offsets respond OKAY.
- WSTRB is honoured per byte lane on RW registers.
- Source path:
  - `act[i] = intr_in[i] ^ POLARITY[i]`; `act_d` is `act` delayed one cycle.
  - Event: edge mode = `act & ~act_d`; level mode = `act`.
- `PENDING[i]` sets on `event[i] & IER[i]` or an ISR write of 1. It clears on an IAR write of 1. If set and clear land in the same cycle, set wins.
  - In level mode, a still-active source re-pends on the cycle after the clear.
- `cond = GIE & |(PENDING & IER)`.
  - Level style: `irq = cond ? C_IRQ_ACTIVE_STATE : ~C_IRQ_ACTIVE_STATE`.
  - Pulse style: `irq` is active for exactly one cycle on each 0->1 transition of `cond`.
- Clearing IER[i] masks PENDING[i] from `irq` but does not clear it.

## Timing
- Reset values:
  - Registers: GIE = IER = PENDING = POLARITY = 0; MODE = C_MODE_RESET; `act_d` = 0.
  - Outputs: AWREADY = WREADY = ARREADY = BVALID = RVALID = 0; BRESP = RRESP = 0; RDATA = 0; `irq = ~C_IRQ_ACTIVE_STATE`.
- Reset mid-transaction aborts it: BVALID/RVALID drop and no response is issued.
- Write handshake: single outstanding transaction.
  - AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & ~BVALID.
  - The register update takes effect on that same edge.
  - BVALID rises the next cycle and holds until BREADY.
  - AW without W (or the reverse) waits.
- Read handshake:
  - ARREADY pulses for one cycle when ARVALID & ~RVALID.
  - RDATA/RVALID are registered the next cycle and held until RREADY.
- Latencies:
  - Source to PENDING: 2 cycles. `intr_in` edge at cycle n gives `act` registered at n+1 and PENDING at n+2.
  - PENDING to `irq`: 1 cycle, registered.
  - A GIE/IER write changes `irq` 1 cycle after the write edge.
- Simultaneous read and write: both proceed independently. A read of PENDING in the cycle of an IAR write returns the pre-write value.

## Test plan
- Reset with C_IRQ_ACTIVE_STATE=1 -> all registers read 0 except MODE = 32'hFFFFFFFF (masked to C_NUM_INTR bits); `irq` = 0; no VALID asserted.
- C_NUM_INTR=4, edge mode. Write GIE=1, IER=4'hF; pulse `intr_in[2]` for one cycle -> PENDING = 0x4 two cycles later and `irq`=1. Write IAR=0x4 -> PENDING = 0 and `irq`=0 one cycle after.
- Level mode (MODE=0) with `intr_in[1]` held high. Write IAR=0x2 -> PENDING bit1 reads 1 again. Drop the source, then IAR=0x2 -> PENDING = 0.
- POLARITY=0x1 with `intr_in[0]` falling 1->0 in edge mode -> PENDING bit0 set. A rising edge sets nothing.
- IER=0 with a source pulsed -> PENDING stays 0. ISR write 0x8 with IER=0x8, GIE=0 -> PENDING = 0x8 and `irq` inactive. Then GIE=1 -> `irq` asserts next cycle.
- C_IRQ_SENSITIVITY=1: two sources pending back-to-back -> a single one-cycle `irq` pulse. Read at 0x20 -> RRESP=2'b10, RDATA=0. BREADY held low for 5 cycles -> BVALID held, and AWREADY stays 0 for a second write.
